// File: rtl/agc_cycle_scheduler_if.sv
// Sequencer-side handshake bundle for the AGC cycle scheduler.
// The scheduler is the master: it drives the decision and stolen-cycle request.
interface agc_cycle_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              boundary;
    logic              resume;
    logic              cyc_done;
    logic              instr_go;
    logic              cyc_valid;
    logic [1:0]        cyc_type;
    logic [ADDR_W-1:0] cyc_addr;
    logic              cyc_dir;

    modport master (
        input  boundary, resume, cyc_done,
        output instr_go, cyc_valid, cyc_type, cyc_addr, cyc_dir
    );

    modport slave (
        output boundary, resume, cyc_done,
        input  instr_go, cyc_valid, cyc_type, cyc_addr, cyc_dir
    );
endinterface

// File: rtl/agc_cycle_scheduler.sv
// Instruction-boundary scheduler: releases instructions, steals counter
// cycles or enters RUPT each time the sequencer parks in Load.
module agc_cycle_scheduler #(
    parameter int                NCNT      = 8,
    parameter int                NIRQ      = 5,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] CNT_BASE  = ADDR_W'(20),
    parameter logic [ADDR_W-1:0] RUPT_BASE = ADDR_W'(2048),
    parameter int                MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCNT-1:0]       inc_req,
    input  logic [NCNT-1:0]       dec_req,
    input  logic [NIRQ-1:0]       irq,
    input  logic                  inhint,
    input  logic                  ext_flag,
    agc_cycle_scheduler_if.master bus,
    output logic                  in_rupt,
    output logic                  cnt_lost
);
    localparam int CW = (NCNT > 1) ? $clog2(NCNT) : 1;
    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_RUPT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              go_q, go_d;
    logic              valid_q, valid_d;
    logic [1:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic              in_rupt_q, in_rupt_d;
    logic              lost_q, lost_d;
    logic [NIRQ-1:0]   irq_pend_q, irq_pend_d;
    logic [NIRQ-1:0]   grant;
    logic signed [2:0] pend_q [NCNT];
    logic signed [2:0] pend_d [NCNT];
    logic [3:0]        nv;

    logic              cnt_hit, cnt_up;
    logic [CW-1:0]     cnt_sel;
    logic              irq_hit;
    logic [IW-1:0]     irq_sel;
    logic [NIRQ-1:0]   irq_oh;

    // Step toward zero on a finished counter cycle, then add the net
    // request; a request that would leave -3..+3 is dropped ({lost, pend}).
    function automatic logic [3:0] pend_next(
        input logic signed [2:0] p,
        input logic              up,
        input logic              dn,
        input logic              stp
    );
        logic signed [3:0] b;
        logic signed [3:0] t;
        b = {p[2], p};
        if (stp && p > 3'sd0) b = b - 4'sd1;
        else if (stp && p < 3'sd0) b = b + 4'sd1;
        t = b;
        if (up && !dn) t = b + 4'sd1;
        else if (dn && !up) t = b - 4'sd1;
        if (t > 4'sd3 || t < -4'sd3) return {1'b1, b[2:0]};
        return {1'b0, t[2:0]};
    endfunction

    // Lowest-index pending counter and lowest eligible interrupt line.
    always_comb begin
        cnt_hit = 1'b0;
        cnt_sel = '0;
        cnt_up  = 1'b0;
        for (int i = NCNT - 1; i >= 0; i--) begin
            if (pend_q[i] != 3'sd0) begin
                cnt_hit = 1'b1;
                cnt_sel = CW'(i);
                cnt_up  = ~pend_q[i][2];
            end
        end
        irq_hit = 1'b0;
        irq_sel = '0;
        irq_oh  = '0;
        for (int j = NIRQ - 1; j >= 0; j--) begin
            if (irq_pend_q[j] && !inhint && !ext_flag && !in_rupt_q) begin
                irq_hit   = 1'b1;
                irq_sel   = IW'(j);
                irq_oh    = '0;
                irq_oh[j] = 1'b1;
            end
        end
    end

    // Pending counter nets and the saturation-drop flag.
    always_comb begin
        lost_d = 1'b0;
        nv     = '0;
        for (int i = 0; i < NCNT; i++) begin
            nv = pend_next(pend_q[i], inc_req[i], dec_req[i],
                           state_q == S_CNT && bus.cyc_done &&
                           idx_q == CW'(i));
            pend_d[i] = nv[2:0];
            lost_d    = lost_d | nv[3];
        end
    end

    // Boundary arbitration and stolen-cycle lifetime.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        go_d      = 1'b0;
        valid_d   = valid_q;
        type_d    = type_q;
        addr_d    = addr_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        in_rupt_d = in_rupt_q;
        grant     = '0;
        if (bus.resume && state_q != S_RUPT) in_rupt_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.boundary) begin
                    if (burst_q == BW'(MAX_BURST)) begin
                        go_d    = 1'b1;
                        burst_d = '0;
                        state_d = S_HOLD;
                    end else if (cnt_hit) begin
                        state_d = S_CNT;
                        valid_d = 1'b1;
                        type_d  = 2'd1;
                        addr_d  = CNT_BASE + ADDR_W'(cnt_sel);
                        dir_d   = cnt_up;
                        idx_d   = cnt_sel;
                        burst_d = burst_q + BW'(1);
                    end else if (irq_hit) begin
                        state_d = S_RUPT;
                        valid_d = 1'b1;
                        type_d  = 2'd2;
                        addr_d  = RUPT_BASE + ADDR_W'({irq_sel, 2'b00});
                        grant   = irq_oh;
                    end else begin
                        go_d    = 1'b1;
                        burst_d = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: state_d = S_IDLE;
            S_CNT, S_RUPT: begin
                if (bus.cyc_done) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    type_d  = 2'd0;
                    addr_d  = '0;
                    dir_d   = 1'b0;
                    if (state_q == S_RUPT) begin
                        in_rupt_d = 1'b1;
                        burst_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        irq_pend_d = (irq_pend_q & ~grant) | irq;
    end

    // State registers; reset discards all pending work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            burst_q    <= '0;
            go_q       <= 1'b0;
            valid_q    <= 1'b0;
            type_q     <= 2'd0;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            idx_q      <= '0;
            in_rupt_q  <= 1'b0;
            lost_q     <= 1'b0;
            irq_pend_q <= '0;
            for (int i = 0; i < NCNT; i++) pend_q[i] <= 3'sd0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            go_q       <= go_d;
            valid_q    <= valid_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            idx_q      <= idx_d;
            in_rupt_q  <= in_rupt_d;
            lost_q     <= lost_d;
            irq_pend_q <= irq_pend_d;
            for (int i = 0; i < NCNT; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign bus.instr_go  = go_q;
    assign bus.cyc_valid = valid_q;
    assign bus.cyc_type  = type_q;
    assign bus.cyc_addr  = addr_q;
    assign bus.cyc_dir   = dir_q;
    assign in_rupt       = in_rupt_q;
    assign cnt_lost      = lost_q;
endmodule

// File: doc/agc_cycle_scheduler.md
# agc_cycle_scheduler

Instruction-boundary scheduler for the AGC build. It sits between the counter/interrupt sources and the control-pulse sequencer. Each time the sequencer parks in its fetch/Load state, the scheduler chooses one of three actions: release the next instruction, steal a cycle for an involuntary counter increment/decrement, or enter an interrupt (RUPT) at a vector address. It tracks pending counter work, pending interrupts, the in-interrupt flag and starvation.

## Interface
- `NCNT`, 8: number of counter cells.
- `NIRQ`, 5: number of interrupt lines.
- `ADDR_W`, 12: erasable/fixed address width.
- `CNT_BASE`, 12'd20: address of counter cell 0 (octal 24).
- `RUPT_BASE`, 12'd2048: address of interrupt vector 0 (octal 4000); vectors are 4 words apart.
- `MAX_BURST`, 4: maximum consecutive counter cycles before one instruction is forced.

- `clk` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inc_req` in NCNT: one-cycle request pulses, +1 to counter i.
- `dec_req` in NCNT: one-cycle request pulses, −1 to counter i.
- `irq` in NIRQ: interrupt request lines, sampled every cycle.
- `inhint` in 1: level; interrupts inhibited (INHINT/RELINT state).
- `ext_flag` in 1: sequencer extracode flag; no interrupt while 1.
- `boundary` in 1: level; sequencer parked in Load awaiting a decision.
- `resume` in 1: one-cycle pulse; RESUME executed, leave interrupt.
- `cyc_done` in 1: one-cycle pulse; datapath finished the stolen cycle.
- `instr_go` out 1: one-cycle pulse; sequencer may decode the next instruction.
- `cyc_valid` out 1: stolen-cycle request, held until `cyc_done`.
- `cyc_type` out 2: 0 none, 1 counter, 2 rupt.
- `cyc_addr` out ADDR_W: counter or vector address.
- `cyc_dir` out 1: counter direction, 1 = increment, 0 = decrement.
- `in_rupt` out 1: an interrupt routine is active.
- `cnt_lost` out 1: one-cycle pulse; a counter request was dropped at saturation.

## Operation
- Per-counter pending register `pend[i]` is 3-bit signed, range −3..+3, and holds the net of requests.
  - `inc_req[i]` and `dec_req[i]` in the same cycle cancel.
  - A request that would exceed ±3 is dropped and pulses `cnt_lost` on the next cycle.
- Per-line `irq_pend[j]` is set whenever `irq[j]` = 1 and cleared when that interrupt is granted.
- States:
  - IDLE: waiting for `boundary`.
  - HOLD: one cycle after `instr_go`; ignores `boundary`.
  - CNT: counter cycle outstanding.
  - RUPT: interrupt entry outstanding.
- Arbitration happens in IDLE when `boundary` = 1, using registered state only. First match wins:
  1. If `burst` = MAX_BURST: instr_go, `burst` ← 0, go to HOLD.
  2. If any `pend[i]` ≠ 0 (lowest i wins): go to CNT with `cyc_addr` = CNT_BASE+i and `cyc_dir` = (`pend[i]` > 0); `burst` += 1.
  3. If any `irq_pend[j]` and !`inhint` and !`ext_flag` and !`in_rupt` (lowest j wins): go to RUPT with `cyc_addr` = RUPT_BASE+4j; clear `irq_pend[j]`.
  4. Otherwise: instr_go, `burst` ← 0, go to HOLD.
- CNT exit: on `cyc_done`, `pend[i]` moves one step toward 0, combined with any same-cycle request on i. Then go to IDLE.
- RUPT exit: on `cyc_done`, `in_rupt` ← 1, `burst` ← 0, go to IDLE.
- `resume` clears `in_rupt`, except in state RUPT, where it is ignored.
- HOLD always returns to IDLE after one cycle.
- `cyc_done` outside CNT/RUPT is ignored.

## Timing
- Reset values: state IDLE; all `pend`, `irq_pend`, `burst` and `in_rupt` = 0; every output = 0.
- Reset mid-cycle drops `cyc_valid` on the next edge. Requests present during `reset` are discarded.
- Decision latency: `boundary` sampled high at edge N → `instr_go` or `cyc_valid` high after edge N.
- `cyc_valid`, `cyc_type`, `cyc_addr` and `cyc_dir` stay stable from assertion until the edge that samples `cyc_done`. They drop to 0 after that edge.
- Minimum stolen cycle is 2 clocks: request and done are never in the same cycle.
- Back-to-back counter cycles: done at edge N → IDLE; if `boundary` is still 1, the next `cyc_valid` rises at N+1.
- An `irq` asserted in the same cycle as arbitration is visible only at the next arbitration.

## Test plan
- After reset, hold `boundary` = 1 with no requests → `instr_go` pulses every 2 cycles (IDLE/HOLD). `cyc_valid` stays 0 and `in_rupt` = 0.
- Pulse `inc_req[3]` twice, then `boundary` = 1 with `cyc_done` 2 cycles after each `cyc_valid` → two CNT cycles at address 23, `cyc_dir` = 1, then `instr_go`.
- Pulse `inc_req[0]` and `dec_req[0]` together → no CNT cycle. Pulse `inc_req[1]` four times → `pend` saturates at 3 and `cnt_lost` pulses once.
- Keep `pend[5]` refilled continuously → exactly 4 CNT cycles, then one `instr_go`, repeating; instructions are never starved.
- `irq[2]` = 1 with `inhint` = 0 → RUPT at address 2056, then `in_rupt` = 1. A second `irq[0]` is not taken until a `resume` pulse, then it vectors to 2048.
- `irq[1]` with `ext_flag` = 1, then with `inhint` = 1 → `instr_go` only, no RUPT. Assert `reset` during an outstanding CNT → all outputs 0 next cycle and `pend` cleared.
